// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - reaction time measurement from stimulus pulse to response pulse
//
// Purpose: arms on start, measures milliseconds from the stimulus pulse
// (delayImpulse) to the response pulse. Detects false starts and timeouts,
// and holds the result for the display path.
// Optional feature macro: REACTION_BEST_EN enables the best_time register.
//
// Ports:
//   clk           : system clock, rising edge
//   rst           : asynchronous reset, active high
//   start         : pulse, arms (or re-arms) a trial
//   delayImpulse  : pulse, stimulus event
//   response      : pulse, debounced response button
//   reaction_time : measured ms, 0..TIMEOUT_MS
//   result_valid  : high while a result is held
//   done_pulse    : one cycle on entry to the held-result state
//   early         : false-start flag
//   timeout       : no-response flag
//   stimulus_on   : high while measuring (stimulus LED)
//   best_time     : minimum valid reaction time (0 when feature disabled)
module reaction_timer #(
  parameter int CLKS_PER_MS = 1,
  parameter int TIMEOUT_MS  = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        delayImpulse,
  input  logic        response,
  output logic [13:0] reaction_time,
  output logic        result_valid,
  output logic        done_pulse,
  output logic        early,
  output logic        timeout,
  output logic        stimulus_on,
  output logic [13:0] best_time
);

  localparam int              PW   = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [13:0]     TMAX = 14'(TIMEOUT_MS);
  localparam logic [PW-1:0]   PMAX = PW'(CLKS_PER_MS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [13:0]   ms_cnt;
  logic          tick;
  logic [13:0]   ms_next;

  // The ms count including the tick of the current cycle, so a response on
  // the cycle right after the impulse already reads 1 ms. Saturates at TMAX.
  assign tick    = (presc == PMAX);
  assign ms_next = (tick && (ms_cnt != TMAX)) ? ms_cnt + 14'd1 : ms_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      presc         <= '0;
      ms_cnt        <= '0;
      reaction_time <= '0;
      result_valid  <= 1'b0;
      done_pulse    <= 1'b0;
      early         <= 1'b0;
      timeout       <= 1'b0;
      stimulus_on   <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (start) begin
        // start has priority over every other event in every state
        state         <= ARMED;
        presc         <= '0;
        ms_cnt        <= '0;
        reaction_time <= '0;
        result_valid  <= 1'b0;
        early         <= 1'b0;
        timeout       <= 1'b0;
        stimulus_on   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          ARMED: begin
            // response wins over a simultaneous impulse: false start
            if (response) begin
              state         <= DONE;
              early         <= 1'b1;
              reaction_time <= '0;
              result_valid  <= 1'b1;
              done_pulse    <= 1'b1;
            end else if (delayImpulse) begin
              state       <= MEASURE;
              presc       <= '0;
              ms_cnt      <= '0;
              stimulus_on <= 1'b1;
            end
          end
          MEASURE: begin
            presc  <= tick ? '0 : presc + PW'(1);
            ms_cnt <= ms_next;
            if (response) begin
              state         <= DONE;
              reaction_time <= ms_next;
              result_valid  <= 1'b1;
              done_pulse    <= 1'b1;
              stimulus_on   <= 1'b0;
            end else if (ms_next == TMAX) begin
              state         <= DONE;
              timeout       <= 1'b1;
              reaction_time <= TMAX;
              result_valid  <= 1'b1;
              done_pulse    <= 1'b1;
              stimulus_on   <= 1'b0;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef REACTION_BEST_EN
  logic [13:0] best_q;

  // Updated on the same edge that enters DONE, so best_time already
  // reflects the new result during the done_pulse cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= TMAX;
    end else if (!start && (state == MEASURE) && response && (ms_next < best_q)) begin
      best_q <= ms_next;
    end
  end

  assign best_time = best_q;
`else
  assign best_time = 14'd0;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - self-checking bench for reaction_timer
module tb_reaction_timer;

  localparam int TMO = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        delay_impulse = 1'b0;
  logic        response = 1'b0;
  logic [13:0] reaction_time;
  logic        result_valid;
  logic        done_pulse;
  logic        early;
  logic        timeout;
  logic        stimulus_on;
  logic [13:0] best_time;

  int n_tests = 0;
  int n_fail  = 0;
  int best_model = TMO;

  reaction_timer #(.CLKS_PER_MS(1), .TIMEOUT_MS(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .delayImpulse (delay_impulse),
    .response     (response),
    .reaction_time(reaction_time),
    .result_valid (result_valid),
    .done_pulse   (done_pulse),
    .early        (early),
    .timeout      (timeout),
    .stimulus_on  (stimulus_on),
    .best_time    (best_time)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int best_exp();
`ifdef REACTION_BEST_EN
    return best_model;
`else
    return 0;
`endif
  endfunction

  // Caller sits just after a negedge; the pulse is seen by exactly one posedge.
  task automatic pulse(input logic s, input logic d, input logic r);
    start = s; delay_impulse = d; response = r;
    @(negedge clk);
    start = 1'b0; delay_impulse = 1'b0; response = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full valid trial: response rt cycles after the impulse cycle.
  task automatic run_trial(input string tag, input int pre, input int rt);
    pulse(1, 0, 0);
    idle(pre);
    pulse(0, 1, 0);
    check({tag, ".stim_on"}, stimulus_on, 1);
    idle(rt - 1);
    check({tag, ".pending"}, result_valid, 0);
    pulse(0, 0, 1);
    if (rt < best_model) best_model = rt;
    check({tag, ".rt"}, reaction_time, rt);
    check({tag, ".valid"}, result_valid, 1);
    check({tag, ".done_pulse"}, done_pulse, 1);
    check({tag, ".early"}, early, 0);
    check({tag, ".timeout"}, timeout, 0);
    check({tag, ".stim_off"}, stimulus_on, 0);
    check({tag, ".best"}, best_time, best_exp());
    idle(1);
    check({tag, ".done_pulse_gone"}, done_pulse, 0);
    check({tag, ".held_rt"}, reaction_time, rt);
  endtask

  // False start: response (optionally with impulse) while armed.
  task automatic early_trial(input string tag, input int pre, input logic simult);
    logic saw_stim;
    saw_stim = 1'b0;
    pulse(1, 0, 0);
    for (int i = 0; i < pre; i++) begin
      saw_stim |= stimulus_on;
      @(negedge clk);
    end
    pulse(0, simult, 1);
    saw_stim |= stimulus_on;
    check({tag, ".early"}, early, 1);
    check({tag, ".rt"}, reaction_time, 0);
    check({tag, ".valid"}, result_valid, 1);
    check({tag, ".done_pulse"}, done_pulse, 1);
    check({tag, ".timeout"}, timeout, 0);
    check({tag, ".no_stim"}, saw_stim, 0);
    check({tag, ".best"}, best_time, best_exp());
    idle(1);
    check({tag, ".stim_after"}, stimulus_on, 0);
  endtask

  initial begin
    int cnt;
    int kind;
    #1;
    check("reset.rt", reaction_time, 0);
    check("reset.valid", result_valid, 0);
    check("reset.done", done_pulse, 0);
    check("reset.early", early, 0);
    check("reset.timeout", timeout, 0);
    check("reset.stim", stimulus_on, 0);
    check("reset.best", best_time, best_exp());
    idle(2);
    rst = 1'b0;
    idle(1);

    // Best-time sequence
    run_trial("best300", 3, 300);
    run_trial("best180", 3, 180);
    early_trial("best_early", 4, 1'b0);
    run_trial("best240", 3, 240);
    check("best.final", best_time, best_exp());

    // Normal trial, impulse 20 cycles after start
    run_trial("normal", 19, 250);
    run_trial("rt1", 2, 1);

    // False starts
    early_trial("false_start", 10, 1'b0);
    early_trial("simult_imp_resp", 5, 1'b1);

    // Ignored inputs in IDLE/DONE: response and impulse in DONE keep result
    pulse(0, 1, 1);
    check("done_ignore.early", early, 1);
    check("done_ignore.stim", stimulus_on, 0);

    // start + response together in MEASURE restarts the trial
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    idle(30);
    pulse(1, 0, 1);
    check("restart.valid", result_valid, 0);
    check("restart.stim", stimulus_on, 0);
    check("restart.early", early, 0);
    check("restart.rt", reaction_time, 0);
    pulse(0, 1, 0);
    check("restart.armed", stimulus_on, 1);
    idle(6);
    pulse(0, 0, 1);
    check("restart.rt2", reaction_time, 7);
    if (7 < best_model) best_model = 7;

    // Timeout
    pulse(1, 0, 0);
    idle(2);
    pulse(0, 1, 0);
    cnt = 0;
    while (!result_valid && cnt < 12000) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout.cycles", cnt, TMO);
    check("timeout.flag", timeout, 1);
    check("timeout.rt", reaction_time, TMO);
    check("timeout.early", early, 0);
    check("timeout.done_pulse", done_pulse, 1);
    check("timeout.best", best_time, best_exp());

    // Randomized trials
    for (int t = 0; t < 25; t++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) early_trial("rand_early", $urandom_range(0, 20), 1'($urandom_range(0, 1)));
      else run_trial("rand_trial", $urandom_range(0, 30), $urandom_range(1, 400));
    end

    // Async reset mid-measure
    pulse(1, 0, 0);
    idle(5);
    pulse(0, 1, 0);
    idle(99);
    #2 rst = 1'b1;
    #1;
    best_model = TMO;
    check("rst.stim", stimulus_on, 0);
    check("rst.valid", result_valid, 0);
    check("rst.rt", reaction_time, 0);
    check("rst.best", best_time, best_exp());
    @(negedge clk);
    rst = 1'b0;
    pulse(0, 1, 0);
    idle(3);
    check("rst.imp_ignored", stimulus_on, 0);
    pulse(0, 0, 1);
    check("rst.resp_ignored", result_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
